poly_note_gen: RTL and testbench

POLY_NOTE_GEN -- requirements
Module: poly_note_gen

---
 rtl/poly_note_gen_pkg.sv | 29 ++
 rtl/note_channel.sv | 153 +++++++++++++++
 rtl/poly_note_gen.sv | 98 +++++++++
 tb/tb_poly_note_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/poly_note_gen_pkg.sv
// Shared constants and the level-to-amplitude table for poly_note_gen.
package poly_note_gen_pkg;

  localparam int unsigned LVL_W     = 3;
  localparam int unsigned MAX_LEVEL = 5;
  localparam int unsigned REST_DIV  = 1;
  localparam int unsigned AMP_W     = 16;

  typedef logic [LVL_W-1:0] level_t;

  // Levels above MAX_LEVEL share the loudest amplitude.
  function automatic logic [AMP_W-1:0] amp_of(input level_t lvl);
    logic [AMP_W-1:0] amp;
    case (lvl)
      3'd0:    amp = 16'h0000;
      3'd1:    amp = 16'h0200;
      3'd2:    amp = 16'h0400;
      3'd3:    amp = 16'h0800;
      3'd4:    amp = 16'h1000;
      default: amp = 16'h2000;
    endcase
    return amp;
  endfunction

  function automatic level_t clamp_level(input level_t lvl);
    return (lvl > level_t'(MAX_LEVEL)) ? level_t'(MAX_LEVEL) : lvl;
  endfunction

endpackage

// File: rtl/note_channel.sv
// One tone channel: half-period divider, phase, pending-note slot with valid/ready
// load, and level tracking (ramped toward target when POLY_NOTE_GEN_ENVELOPE_EN).
module note_channel
  import poly_note_gen_pkg::*;
#(
  parameter int unsigned DIV_W = 22,
  parameter int unsigned AUD_W = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef POLY_NOTE_GEN_ENVELOPE_EN
  input  logic             tick,
`endif
  input  logic [DIV_W-1:0] div_i,
  input  logic [LVL_W-1:0] vol_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [AUD_W-1:0] audio_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             phase_q, phase_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ready_q, ready_d;
  level_t           lvl_q, lvl_d;
  level_t           pend_vol_q, pend_vol_d;
  logic [AUD_W-1:0] audio_q, audio_d;
  logic [AUD_W-1:0] amp;
  logic             resting;
  logic             toggle;
  logic             activate;
`ifdef POLY_NOTE_GEN_ENVELOPE_EN
  level_t           tgt_q, tgt_d;
  logic             rest_req_q, rest_req_d;
`endif

  // Divider, activation, load handshake and sample generation.
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    phase_d    = phase_q;
    pend_vld_d = pend_vld_q;
    lvl_d      = lvl_q;
    pend_vol_d = pend_vol_q;
    audio_d    = audio_q;
`ifdef POLY_NOTE_GEN_ENVELOPE_EN
    tgt_d      = tgt_q;
    rest_req_d = rest_req_q;
`endif
    resting  = (div_q <= DIV_W'(REST_DIV));
    toggle   = !resting && (cnt_q == div_q);
    activate = pend_vld_q && (resting || toggle);
    amp      = AUD_W'(amp_of(lvl_q));

    if (resting) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (toggle) begin
      cnt_d   = '0;
      phase_d = !phase_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

`ifdef POLY_NOTE_GEN_ENVELOPE_EN
    if (tick) begin
      if (lvl_q < tgt_q) begin
        lvl_d = lvl_q + LVL_W'(1);
      end else if (lvl_q > tgt_q) begin
        lvl_d = lvl_q - LVL_W'(1);
      end
    end
    // A requested rest waits for the fade-out to finish before stopping the divider.
    if (rest_req_q && (lvl_q == '0)) begin
      div_d      = DIV_W'(REST_DIV);
      rest_req_d = 1'b0;
    end
    if (activate) begin
      pend_vld_d = 1'b0;
      if (pend_div_q <= DIV_W'(REST_DIV)) begin
        tgt_d      = '0;
        rest_req_d = !resting;
      end else begin
        tgt_d      = clamp_level(pend_vol_q);
        div_d      = pend_div_q;
        rest_req_d = 1'b0;
      end
    end
`else
    if (activate) begin
      pend_vld_d = 1'b0;
      div_d      = pend_div_q;
      lvl_d      = pend_vol_q;
    end
`endif

    if (valid_i && ready_q) begin
      pend_vld_d = 1'b1;
      pend_div_d = div_i;
      pend_vol_d = vol_i;
    end
    ready_d = !pend_vld_d;

    if (resting) begin
      audio_d = '0;
    end else begin
      audio_d = phase_q ? amp : -amp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      div_q      <= DIV_W'(REST_DIV);
      pend_div_q <= '0;
      phase_q    <= 1'b0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      lvl_q      <= '0;
      pend_vol_q <= '0;
      audio_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      phase_q    <= phase_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
      lvl_q      <= lvl_d;
      pend_vol_q <= pend_vol_d;
      audio_q    <= audio_d;
    end
  end

`ifdef POLY_NOTE_GEN_ENVELOPE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q      <= '0;
      rest_req_q <= 1'b0;
    end else begin
      tgt_q      <= tgt_d;
      rest_req_q <= rest_req_d;
    end
  end
`endif

  assign ready_o = ready_q;
  assign audio_o = audio_q;

endmodule

// File: rtl/poly_note_gen.sv
// Polyphonic square-wave note generator: NCH note_channel instances and a saturating mixer.
// Optional envelope ramp with a shared step tick: define POLY_NOTE_GEN_ENVELOPE_EN.
module poly_note_gen
  import poly_note_gen_pkg::*;
#(
  parameter int unsigned NCH      = 2,
  parameter int unsigned DIV_W    = 22,
  parameter int unsigned AUD_W    = 16,
  parameter int unsigned RAMP_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*DIV_W-1:0] note_div,
  input  logic [NCH*LVL_W-1:0] note_vol,
  input  logic [NCH-1:0]       note_valid,
  output logic [NCH-1:0]       note_ready,
  output logic [NCH*AUD_W-1:0] audio,
  output logic [AUD_W-1:0]     mix_out
);

  localparam int unsigned SUM_W = AUD_W + $clog2(NCH);
  localparam logic signed [SUM_W-1:0] MIX_MAX = SUM_W'((2 ** (AUD_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] MIX_MIN = ~MIX_MAX;

  if ((NCH == 0) || (NCH > 8) || (RAMP_CYC == 0)) begin : g_bad_param
    $error("poly_note_gen: NCH must be 1..8 and RAMP_CYC at least 1");
  end

`ifdef POLY_NOTE_GEN_ENVELOPE_EN
  localparam int unsigned TICK_W = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  // Free-running step tick shared by every channel's envelope.
  always_comb begin
    tick       = (tick_cnt_q == TICK_W'(RAMP_CYC - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end
`endif

  logic [AUD_W-1:0] ch_audio [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    note_channel #(
      .DIV_W (DIV_W),
      .AUD_W (AUD_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
`ifdef POLY_NOTE_GEN_ENVELOPE_EN
      .tick    (tick),
`endif
      .div_i   (note_div[i*DIV_W +: DIV_W]),
      .vol_i   (note_vol[i*LVL_W +: LVL_W]),
      .valid_i (note_valid[i]),
      .ready_o (note_ready[i]),
      .audio_o (ch_audio[i])
    );
    assign audio[i*AUD_W +: AUD_W] = ch_audio[i];
  end

  logic signed [SUM_W-1:0] sum;
  logic [AUD_W-1:0]        mix_q, mix_d;

  // Wide signed sum of the registered channel samples, clamped to AUD_W.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NCH; i++) begin
      sum = sum + SUM_W'($signed(ch_audio[i]));
    end
    mix_d = sum[AUD_W-1:0];
    if (sum > MIX_MAX) begin
      mix_d = {1'b0, {(AUD_W-1){1'b1}}};
    end else if (sum < MIX_MIN) begin
      mix_d = {1'b1, {(AUD_W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  assign mix_out = mix_q;

endmodule

// File: tb/tb_poly_note_gen.sv
// Directed bench for poly_note_gen: a 2-channel and a 4-channel instance, RAMP_CYC=4.
module tb_poly_note_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [43:0] div2 = '0;
  logic [5:0]  vol2 = '0;
  logic [1:0]  vld2 = '0;
  logic [1:0]  rdy2;
  logic [31:0] aud2;
  logic [15:0] mix2;

  logic [87:0] div4 = '0;
  logic [11:0] vol4 = '0;
  logic [3:0]  vld4 = '0;
  logic [3:0]  rdy4;
  logic [63:0] aud4;
  logic [15:0] mix4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  poly_note_gen #(.NCH(2), .DIV_W(22), .AUD_W(16), .RAMP_CYC(4)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .note_div   (div2),
    .note_vol   (vol2),
    .note_valid (vld2),
    .note_ready (rdy2),
    .audio      (aud2),
    .mix_out    (mix2)
  );

  poly_note_gen #(.NCH(4), .DIV_W(22), .AUD_W(16), .RAMP_CYC(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .note_div   (div4),
    .note_vol   (vol4),
    .note_valid (vld4),
    .note_ready (rdy4),
    .audio      (aud4),
    .mix_out    (mix4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic seg_a0(input string tag, input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, 64'(aud2[15:0]), 64'(v));
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    vld2 = '0;
    vld4 = '0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] exp_a;
    logic [15:0] prev;
    logic        found;

    do_reset();
    chk("rst_aud2",  64'(aud2), 64'd0);
    chk("rst_mix2",  64'(mix2), 64'd0);
    chk("rst_rdy2",  64'(rdy2), 64'h3);
    chk("rst_aud4",  aud4,      64'd0);
    chk("rst_mix4",  64'(mix4), 64'd0);
    chk("rst_rdy4",  64'(rdy4), 64'hF);

`ifndef POLY_NOTE_GEN_ENVELOPE_EN
    // div=3 vol=5: 8-cycle square 0xE000/0x2000, mix trails audio by one cycle
    div2[21:0] = 22'd3; vol2[2:0] = 3'd5; vld2[0] = 1'b1;
    step();
    vld2[0] = 1'b0;
    chk("sq_ready_low", 64'(rdy2[0]), 64'd0);
    step();
    chk("sq_ready_high", 64'(rdy2[0]), 64'd1);
    chk("sq_aud_start",  64'(aud2[15:0]), 64'd0);
    prev = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      step();
      exp_a = (((k / 4) % 2) == 0) ? 16'hE000 : 16'h2000;
      chk("sq_audio0", 64'(aud2[15:0]), 64'(exp_a));
      chk("sq_mix_dly", 64'(mix2), 64'(prev));
      prev = exp_a;
    end

    // div=9 retuned to div=4 mid half-period: 10-cycle half completes, then 5-cycle halves
    do_reset();
    div2[21:0] = 22'd9; vol2[2:0] = 3'd5; vld2[0] = 1'b1;
    step();
    vld2[0] = 1'b0;
    step();
    seg_a0("rt_old_half", 16'hE000, 2);
    div2[21:0] = 22'd4; vld2[0] = 1'b1;
    seg_a0("rt_old_half", 16'hE000, 1);
    vld2[0] = 1'b0;
    chk("rt_ready_pend", 64'(rdy2[0]), 64'd0);
    seg_a0("rt_old_half", 16'hE000, 6);
    chk("rt_ready_hold", 64'(rdy2[0]), 64'd0);
    seg_a0("rt_old_half", 16'hE000, 1);
    chk("rt_ready_back", 64'(rdy2[0]), 64'd1);
    seg_a0("rt_new_hi", 16'h2000, 5);
    seg_a0("rt_new_lo", 16'hE000, 5);
    seg_a0("rt_new_hi2", 16'h2000, 5);

    // request while not ready is dropped: div=5 stays active, later div=3 load takes effect
    do_reset();
    div2[21:0] = 22'd5; vol2[2:0] = 3'd5; vld2[0] = 1'b1;
    step();
    div2[21:0] = 22'd3;
    chk("ign_ready_low", 64'(rdy2[0]), 64'd0);
    step();
    vld2[0] = 1'b0;
    chk("ign_ready_high", 64'(rdy2[0]), 64'd1);
    seg_a0("ign_d5_lo", 16'hE000, 6);
    seg_a0("ign_d5_hi", 16'h2000, 6);
    chk("ign_no_pend", 64'(rdy2[0]), 64'd1);
    div2[21:0] = 22'd3; vld2[0] = 1'b1;
    seg_a0("ign_d5_lo2", 16'hE000, 1);
    vld2[0] = 1'b0;
    seg_a0("ign_d5_lo2", 16'hE000, 5);
    seg_a0("ign_d3_hi", 16'h2000, 4);
    seg_a0("ign_d3_lo", 16'hE000, 4);

    // four channels at level 7 in lock-step: mix clamps both ways
    do_reset();
    for (int c = 0; c < 4; c++) begin
      div4[c*22 +: 22] = 22'd3;
      vol4[c*3 +: 3]   = 3'd7;
    end
    vld4 = 4'hF;
    step();
    vld4 = 4'h0;
    step();
    step();
    chk("clamp_aud_neg", aud4, 64'hE000E000E000E000);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("clamp_mix_neg", 64'(mix4), 64'h8000);
    end
    chk("clamp_aud_pos", aud4, 64'h2000200020002000);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("clamp_mix_pos", 64'(mix4), 64'h7FFF);
    end

    // no envelope: level 5 applies on the first sample
    do_reset();
    div2[21:0] = 22'd100; vol2[2:0] = 3'd5; vld2[0] = 1'b1;
    step();
    vld2[0] = 1'b0;
    step();
    step();
    chk("noenv_full", 64'(aud2[15:0]), 64'hE000);
`else
    // envelope: level ramps 0->5 one step every 4 cycles (phase 0, so samples are negative)
    do_reset();
    div2[21:0] = 22'd100; vol2[2:0] = 3'd5; vld2[0] = 1'b1;
    step();
    vld2[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      step();
      if (aud2[15:0] == 16'hFE00) found = 1'b1;
    end
    chk("env_first_step", 64'(found), 64'd1);
    seg_a0("env_lvl1", 16'hFE00, 3);
    seg_a0("env_lvl2", 16'hFC00, 4);
    seg_a0("env_lvl3", 16'hF800, 4);
    seg_a0("env_lvl4", 16'hF000, 4);
    seg_a0("env_lvl5", 16'hE000, 4);
`endif

    // reset pulse while loads are pending discards everything
    do_reset();
    div2[21:0] = 22'd9; vol2[2:0] = 3'd5; vld2 = 2'b01;
    step();
    vld2 = 2'b00;
    step();
    step();
    div2[21:0] = 22'd4; div2[43:22] = 22'd5; vol2[5:3] = 3'd5; vld2 = 2'b11;
    step();
    vld2 = 2'b00;
    chk("rp_both_pend", 64'(rdy2), 64'd0);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    chk("rp_aud",  64'(aud2), 64'd0);
    chk("rp_mix",  64'(mix2), 64'd0);
    chk("rp_rdy",  64'(rdy2), 64'h3);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rp_aud_after", 64'(aud2), 64'd0);
      chk("rp_mix_after", 64'(mix2), 64'd0);
      chk("rp_rdy_after", 64'(rdy2), 64'h3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
